// File: rtl/mod_fetch_unit.sv
// Instruction prefetch stage: fills a small queue of sequential words from a
// wait-stated memory and presents the word at the core's pc, refetching on redirect.
module mod_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        advance,
  output logic [31:0] instruction,
  output logic        ins_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  localparam int             PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW         = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
  localparam logic [31:0]    RESET_PC_W = {RESET_PC[31:2], 2'b00};

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   stream_pc, fetch_addr, fetch_nxt, req_addr, pc_w;
  logic          outstanding, discard;
  logic          redirect, ack, pop, push, out_keep, issue;

  always_comb begin
    pc_w        = {pc[31:2], 2'b00};
    redirect    = (pc_w != stream_pc);
    ins_valid   = (count != '0) && !redirect;
    instruction = ins_valid ? mem[head] : 32'h0;
    ack         = imem_ack && outstanding;
    pop         = advance && ins_valid;
    // a word acked in a redirect cycle, or flagged stale, never enters the queue
    push        = ack && !discard && !redirect;
    count_nxt   = redirect ? '0 : count + CW'(push) - CW'(pop);
    fetch_nxt   = redirect ? pc_w : (push ? fetch_addr + 32'd4 : fetch_addr);
    out_keep    = outstanding && !ack;
    // decided on next-state occupancy so an ack can chain straight into the next request
    issue       = !out_keep && (count_nxt < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      stream_pc   <= RESET_PC_W;
      fetch_addr  <= RESET_PC_W;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      req_addr    <= 32'h0;
    end else begin
      count       <= count_nxt;
      fetch_addr  <= fetch_nxt;
      outstanding <= out_keep || issue;
      if (issue) req_addr <= fetch_nxt;
      if (redirect) begin
        head      <= '0;
        tail      <= '0;
        stream_pc <= pc_w;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop) begin
          head      <= head + PW'(1);
          stream_pc <= stream_pc + 32'd4;
        end
      end
      if (ack)                          discard <= 1'b0;
      else if (redirect && outstanding) discard <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= imem_rdata;
  end

  assign imem_req  = outstanding;
  assign imem_addr = req_addr;

endmodule

// File: tb/tb_mod_fetch_unit.sv
// Bench for mod_fetch_unit: wait-stated memory model plus per-scenario checks
// against address-derived expected words and spec-derived latencies.
module tb_mod_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1, advance = 1'b0, imem_ack = 1'b0;
  logic [31:0] pc = 32'h0, imem_rdata = 32'h0;
  logic [31:0] instruction, imem_addr;
  logic        ins_valid, imem_req;

  int          total = 0, bad = 0;
  int          mem_wait = 1;
  logic [31:0] req_log[$];

  mod_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .pc(pc), .advance(advance),
    .instruction(instruction), .ins_valid(ins_valid),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_0000;
  endfunction

  // memory: acks mem_wait cycles after the request appears, logs each request address
  initial begin
    int waited = 0;
    logic [31:0] start_addr = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        imem_ack = 1'b0; waited = 0;
      end else if (imem_req) begin
        if (waited == 0) begin
          req_log.push_back(imem_addr); start_addr = imem_addr;
        end else begin
          total++;
          if (imem_addr !== start_addr) begin
            bad++; $display("FAIL req_stable addr=%h want=%h", imem_addr, start_addr);
          end
        end
        if (waited >= mem_wait) begin
          imem_ack = 1'b1; imem_rdata = word_of(imem_addr); waited = 0;
        end else begin
          imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; waited++;
        end
      end else begin
        if (waited != 0) begin
          total++; bad++; $display("FAIL req_withdrawn after %0d wait cycles", waited);
        end
        imem_ack = 1'b0; waited = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_log.delete();
    reset = 1'b0;
  endtask

  // counts invalid cycles from the current cycle until ins_valid rises
  task automatic wait_valid(input int bound, output int inv);
    inv = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (ins_valid) return;
      inv++;
    end
    inv = -1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", ins_valid); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instruction); end
  endtask

  task automatic test_sequential();
    int first = -1, delivered = 0;
    mem_wait = 1; pc = 32'h0; advance = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 80 && delivered < 8; cyc++) begin
      logic v;
      @(negedge clk);
      v = ins_valid;
      total++;
      if (v) begin
        if (first < 0) first = cyc;
        if (instruction !== (32'(delivered * 4) ^ 32'hA5A5_0000)) begin
          bad++; $display("FAIL seq_word idx=%0d got=%h want=%h", delivered, instruction,
                          32'(delivered * 4) ^ 32'hA5A5_0000);
        end
      end else if (instruction !== 32'h0) begin
        bad++; $display("FAIL seq_zero got=%h want=0", instruction);
      end
      @(posedge clk); #1;
      if (v) begin pc += 32'd4; delivered++; end
    end
    total++; if (first != 3) begin bad++; $display("FAIL seq_first_valid got=%0d want=3", first); end
    total++; if (delivered != 8) begin bad++; $display("FAIL seq_delivered got=%0d want=8", delivered); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= req_log.size() || req_log[i] !== 32'(i * 4)) begin
        bad++; $display("FAIL seq_req_addr idx=%0d got=%h want=%h", i,
                        (i < req_log.size()) ? req_log[i] : 32'hX, 32'(i * 4));
      end
    end
    advance = 1'b0;
  endtask

  task automatic test_fill();
    mem_wait = 2; pc = 32'h0; advance = 1'b0;
    do_reset();
    repeat (30) @(negedge clk);
    total++; if (req_log.size() != DEPTH) begin bad++; $display("FAIL fill_req_count got=%0d want=%0d", req_log.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < req_log.size(); i++) begin
      total++;
      if (req_log[i] !== 32'(i * 4)) begin bad++; $display("FAIL fill_addr idx=%0d got=%h want=%h", i, req_log[i], 32'(i * 4)); end
    end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fill_req_idle got=%b want=0", imem_req); end
    advance = 1'b1;
    // a full queue must cover DEPTH consecutive pops even with a slow memory
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (ins_valid !== 1'b1 || instruction !== word_of(32'(i * 4))) begin
        bad++; $display("FAIL fill_drain idx=%0d valid=%b got=%h want=%h", i, ins_valid, instruction, word_of(32'(i * 4)));
      end
      @(posedge clk); #1;
      pc += 32'd4;
    end
    advance = 1'b0;
  endtask

  task automatic test_redirect_flush();
    int inv, s0, j;
    mem_wait = 0; pc = 32'h0; advance = 1'b0;
    do_reset();
    repeat (12) @(negedge clk);
    s0 = req_log.size();
    total++; if (ins_valid !== 1'b1 || instruction !== word_of(32'h0)) begin
      bad++; $display("FAIL flush_head valid=%b got=%h want=%h", ins_valid, instruction, word_of(32'h0));
    end
    advance = 1'b1;
    @(posedge clk); #1;
    pc = 32'h100;
    wait_valid(20, inv);
    total++; if (inv != 2) begin bad++; $display("FAIL flush_penalty got=%0d want=2", inv); end
    total++; if (instruction !== word_of(32'h100)) begin bad++; $display("FAIL flush_word got=%h want=%h", instruction, word_of(32'h100)); end
    j = -1;
    for (int i = s0; i < req_log.size(); i++) if (j < 0 && req_log[i] == 32'h100) j = i;
    total++; if (j < 0) begin bad++; $display("FAIL flush_next_addr got=none want=00000100"); end
    for (int i = s0; i < j; i++) begin
      total++;
      if (req_log[i] !== 32'h10) begin bad++; $display("FAIL flush_stray_req got=%h want=00000010", req_log[i]); end
    end
    advance = 1'b0;
  endtask

  task automatic test_redirect_ack();
    int inv, s0;
    mem_wait = 2; pc = 32'h0; advance = 1'b0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_ack && imem_req) break;
    end
    total++; if (!(imem_ack && imem_req)) begin bad++; $display("FAIL rack_no_ack got=%b want=1", imem_ack); end
    pc = 32'h200;
    s0 = req_log.size();
    @(posedge clk);
    wait_valid(20, inv);
    total++; if (inv != 3) begin bad++; $display("FAIL rack_penalty got=%0d want=3", inv); end
    total++; if (instruction !== word_of(32'h200)) begin bad++; $display("FAIL rack_word got=%h want=%h", instruction, word_of(32'h200)); end
    total++; if (s0 >= req_log.size() || req_log[s0] !== 32'h200) begin
      bad++; $display("FAIL rack_next_addr got=%h want=00000200", (s0 < req_log.size()) ? req_log[s0] : 32'hX);
    end
  endtask

  task automatic test_redirect_outstanding();
    int inv, extra;
    mem_wait = 3; pc = 32'h0; advance = 1'b0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h8 && !imem_ack) break;
    end
    pc = 32'h40;
    inv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      inv++;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || ins_valid !== 1'b0) begin
        bad++; $display("FAIL rout_hold cyc=%0d req=%b addr=%h valid=%b want req=1 addr=00000008 valid=0",
                        k, imem_req, imem_addr, ins_valid);
      end
    end
    wait_valid(20, extra);
    total++; if (extra != 4) begin bad++; $display("FAIL rout_penalty got=%0d want=4", extra); end
    total++; if (instruction !== word_of(32'h40)) begin bad++; $display("FAIL rout_word got=%h want=%h", instruction, word_of(32'h40)); end
    total++; if (req_log.size() < 4 || req_log[2] !== 32'h8 || req_log[3] !== 32'h40) begin
      bad++; $display("FAIL rout_req_seq got=%h,%h want=00000008,00000040",
                      (req_log.size() > 2) ? req_log[2] : 32'hX, (req_log.size() > 3) ? req_log[3] : 32'hX);
    end
  endtask

  task automatic test_reset_mid();
    int inv;
    mem_wait = 3; pc = 32'h0; advance = 1'b0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_log.size() == 2 && imem_req) break;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (imem_req !== 1'b0 || ins_valid !== 1'b0 || instruction !== 32'h0) begin
      bad++; $display("FAIL mid_rst req=%b valid=%b instr=%h want 0/0/0", imem_req, ins_valid, instruction);
    end
    @(posedge clk); #1;
    req_log.delete();
    reset = 1'b0;
    wait_valid(20, inv);
    total++; if (inv != 5) begin bad++; $display("FAIL mid_rst_restart got=%0d want=5", inv); end
    total++; if (instruction !== word_of(32'h0)) begin bad++; $display("FAIL mid_rst_word got=%h want=%h", instruction, word_of(32'h0)); end
    total++; if (req_log.size() == 0 || req_log[0] !== 32'h0) begin
      bad++; $display("FAIL mid_rst_addr got=%h want=00000000", (req_log.size() > 0) ? req_log[0] : 32'hX);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int streak = 0, bound;
      mem_wait = $urandom_range(0, 3);
      bound = 2 * mem_wait + 4;
      pc = 32'h0; advance = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 500; cyc++) begin
        logic v;
        @(negedge clk);
        v = ins_valid;
        total++;
        if (v) begin
          streak = 0;
          if (instruction !== word_of(pc)) begin
            bad++; $display("FAIL rnd_word pc=%h got=%h want=%h", pc, instruction, word_of(pc));
          end
        end else begin
          streak++;
          if (instruction !== 32'h0 || streak > bound) begin
            bad++; $display("FAIL rnd_idle pc=%h instr=%h streak=%0d limit=%0d", pc, instruction, streak, bound);
          end
        end
        advance = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
        if (v && advance) pc += 32'd4;
        case ($urandom_range(0, 23))
          0: begin pc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))}; streak = 0; end
          1: begin pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 3)); streak = 0; end
          default: ;
        endcase
      end
    end
    advance = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fill();
    test_redirect_flush();
    test_redirect_ack();
    test_redirect_outstanding();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
